// File: rtl/id_ex_stage_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg_if
//
// Purpose: bundles the decode-side inputs and the execute-side outputs of the
// ID/EX pipeline register so that the stage and its neighbours connect
// through a single port.
//
// Signals:
//   id_valid, id_ctrl[10:0]        decode instruction valid and control word
//   id_pc4, id_rs_data, id_rt_data  PC+4 and register file read data
//   id_imm                          sign-extended immediate
//   id_rs, id_rt, id_rd, id_funct   instruction fields
//   flush                           branch/jump taken in EX
//   stall                           hold PC and IF/ID (combinational)
//   ex_*                            registered EX-stage copies of the above
//   ex_wr_reg                       resolved destination register
//   stall_count[15:0]               stall-cycle counter (0 unless enabled)
//
// Modports:
//   master - decode side / test driver (drives id_* and flush)
//   slave  - the ID/EX stage register itself
// ---------------------------------------------------------------------------
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);

  logic              id_valid;
  logic [10:0]       id_ctrl;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [5:0]        id_funct;
  logic              flush;

  logic              stall;
  logic              ex_valid;
  logic [10:0]       ex_ctrl;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_wr_reg;
  logic [5:0]        ex_funct;
  logic [15:0]       stall_count;

  modport master (
    output id_valid, id_ctrl, id_pc4, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_funct, flush,
    input  stall, ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_wr_reg, ex_funct, stall_count
  );

  modport slave (
    input  id_valid, id_ctrl, id_pc4, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_funct, flush,
    output stall, ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_wr_reg, ex_funct, stall_count
  );

endinterface

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// Purpose: pipeline register between decode and execute of the 32-bit
// MIPS-style core. Captures control, operands, immediate and register
// indices, resolves the destination register (rt, rd or the link register),
// detects load-use hazards (bubble + front-end stall) and honours a flush
// from EX.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    id_ex_stage_reg_if.slave (decode inputs, flush, stall, ex_* outputs,
//          stall_count)
//
// Control word layout (bit 10 down to 0):
//   reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
//   branch, jump, link, alu_op[1:0]
//
// Build option: define STALL_COUNT_EN to build a saturating 16-bit counter of
// stall cycles on stall_count; otherwise stall_count is tied to 0.
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_reg_if.slave bus
);

  localparam int CtlRegDst   = 10;
  localparam int CtlRegWrite = 7;
  localparam int CtlMemRead  = 6;
  localparam int CtlMemWrite = 5;
  localparam int CtlBranch   = 4;
  localparam int CtlLink     = 2;

  logic              exValidQ;
  logic [10:0]       exCtrlQ;
  logic [DATA_W-1:0] exPc4Q;
  logic [DATA_W-1:0] exRsDataQ;
  logic [DATA_W-1:0] exRtDataQ;
  logic [DATA_W-1:0] exImmQ;
  logic [REG_W-1:0]  exRsQ;
  logic [REG_W-1:0]  exRtQ;
  logic [REG_W-1:0]  exWrRegQ;
  logic [5:0]        exFunctQ;

  logic              usesRt;
  logic              hazard;
  logic              stallInt;
  logic [REG_W-1:0]  wrRegNext;

  // rt is a source operand for R-type (reg_dst), stores and branches; for
  // loads and other I-type ops it is only the destination.
  always_comb begin
    usesRt = bus.id_ctrl[CtlRegDst] | bus.id_ctrl[CtlMemWrite] |
             bus.id_ctrl[CtlBranch];
  end

  // Load in EX whose result is needed by the instruction in ID. Register 0 is
  // hard-wired, so a load targeting it never creates a dependency.
  always_comb begin
    hazard = bus.id_valid & exValidQ & exCtrlQ[CtlMemRead] &
             (exRtQ != '0) &
             ((exRtQ == bus.id_rs) | ((exRtQ == bus.id_rt) & usesRt));
    stallInt = hazard & ~bus.flush;
  end

  // Destination resolution; an instruction that does not write the register
  // file reports register 0 so forwarding logic never matches it.
  always_comb begin
    wrRegNext = '0;
    if (bus.id_ctrl[CtlRegWrite]) begin
      if (bus.id_ctrl[CtlLink]) begin
        wrRegNext = REG_W'(LINK_REG);
      end else if (bus.id_ctrl[CtlRegDst]) begin
        wrRegNext = bus.id_rd;
      end else begin
        wrRegNext = bus.id_rt;
      end
    end
  end

  // Flush and stall both insert a bubble; only valid+ctrl are cleared, the
  // data fields keep their previous contents since nothing consumes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValidQ  <= 1'b0;
      exCtrlQ   <= '0;
      exPc4Q    <= '0;
      exRsDataQ <= '0;
      exRtDataQ <= '0;
      exImmQ    <= '0;
      exRsQ     <= '0;
      exRtQ     <= '0;
      exWrRegQ  <= '0;
      exFunctQ  <= '0;
    end else if (bus.flush || stallInt) begin
      exValidQ <= 1'b0;
      exCtrlQ  <= '0;
    end else if (!bus.id_valid) begin
      exValidQ <= 1'b0;
      exCtrlQ  <= '0;
    end else begin
      exValidQ  <= 1'b1;
      exCtrlQ   <= bus.id_ctrl;
      exPc4Q    <= bus.id_pc4;
      exRsDataQ <= bus.id_rs_data;
      exRtDataQ <= bus.id_rt_data;
      exImmQ    <= bus.id_imm;
      exRsQ     <= bus.id_rs;
      exRtQ     <= bus.id_rt;
      exWrRegQ  <= wrRegNext;
      exFunctQ  <= bus.id_funct;
    end
  end

`ifdef STALL_COUNT_EN
  logic [15:0] stallCountQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCountQ <= '0;
    end else if (stallInt && (stallCountQ != 16'hFFFF)) begin
      stallCountQ <= stallCountQ + 16'd1;
    end
  end

  assign bus.stall_count = stallCountQ;
`else
  assign bus.stall_count = 16'd0;
`endif

  assign bus.stall      = stallInt;
  assign bus.ex_valid   = exValidQ;
  assign bus.ex_ctrl    = exCtrlQ;
  assign bus.ex_pc4     = exPc4Q;
  assign bus.ex_rs_data = exRsDataQ;
  assign bus.ex_rt_data = exRtDataQ;
  assign bus.ex_imm     = exImmQ;
  assign bus.ex_rs      = exRsQ;
  assign bus.ex_rt      = exRtQ;
  assign bus.ex_wr_reg  = exWrRegQ;
  assign bus.ex_funct   = exFunctQ;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Directed bench for the ID/EX pipeline register. Each step drives one decode
// instruction, checks the combinational stall, pushes the expected EX state
// to a scoreboard and pops/compares it after the capturing clock edge.
// Define STALL_COUNT_EN for both bench and RTL to check the stall counter.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam logic [10:0] CTRL_RTYPE = 11'b10010000010;
  localparam logic [10:0] CTRL_LW    = 11'b01111000000;
  localparam logic [10:0] CTRL_SW    = 11'b01000100000;
  localparam logic [10:0] CTRL_BEQ   = 11'b00000010001;
  localparam logic [10:0] CTRL_JAL   = 11'b00010001100;

  typedef struct {
    logic        valid;
    logic [10:0] ctrl;
    logic [31:0] pc4;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wrReg;
    logic [5:0]  funct;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [15:0] expCount;
  exp_t sb[$];

  id_ex_stage_reg_if #(.DATA_W(32), .REG_W(5)) bus ();

  id_ex_stage_reg #(.DATA_W(32), .REG_W(5), .LINK_REG(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] expWr(input logic [10:0] c, input logic [4:0] rt,
                                       input logic [4:0] rd);
    if (!c[7])     return 5'd0;
    else if (c[2]) return 5'd31;
    else if (c[10]) return rd;
    else           return rt;
  endfunction

  function automatic logic [15:0] expCountView();
`ifdef STALL_COUNT_EN
    return expCount;
`else
    return 16'd0;
`endif
  endfunction

  task automatic compareEx(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".ex_valid"}, {31'd0, bus.ex_valid}, {31'd0, e.valid});
    chk({tag, ".ex_ctrl"}, {21'd0, bus.ex_ctrl}, {21'd0, e.ctrl});
    if (e.valid) begin
      chk({tag, ".ex_wr_reg"}, {27'd0, bus.ex_wr_reg}, {27'd0, e.wrReg});
      chk({tag, ".ex_pc4"}, bus.ex_pc4, e.pc4);
      chk({tag, ".ex_rs_data"}, bus.ex_rs_data, e.rsData);
      chk({tag, ".ex_rt_data"}, bus.ex_rt_data, e.rtData);
      chk({tag, ".ex_imm"}, bus.ex_imm, e.imm);
      chk({tag, ".ex_rs"}, {27'd0, bus.ex_rs}, {27'd0, e.rs});
      chk({tag, ".ex_rt"}, {27'd0, bus.ex_rt}, {27'd0, e.rt});
      chk({tag, ".ex_funct"}, {26'd0, bus.ex_funct}, {26'd0, e.funct});
    end
    chk({tag, ".stall_count"}, {16'd0, bus.stall_count}, {16'd0, expCountView()});
  endtask

  task automatic drive(input logic v, input logic [10:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic fl);
    bus.id_valid   = v;
    bus.id_ctrl    = c;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_rd      = rd;
    bus.id_pc4     = pc4;
    bus.id_rs_data = $urandom;
    bus.id_rt_data = $urandom;
    bus.id_imm     = $urandom;
    bus.id_funct   = 6'($urandom_range(0, 63));
    bus.flush      = fl;
  endtask

  task automatic step(input string tag, input logic v, input logic [10:0] c,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] pc4, input logic fl, input logic expStall);
    exp_t e;
    @(negedge clk);
    drive(v, c, rs, rt, rd, pc4, fl);
    #1;
    chk({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, expStall});
    e.valid  = v & ~fl & ~expStall;
    e.ctrl   = e.valid ? c : 11'd0;
    e.pc4    = pc4;
    e.rsData = bus.id_rs_data;
    e.rtData = bus.id_rt_data;
    e.imm    = bus.id_imm;
    e.rs     = rs;
    e.rt     = rt;
    e.wrReg  = expWr(c, rt, rd);
    e.funct  = bus.id_funct;
    sb.push_back(e);
    if (expStall && expCount != 16'hFFFF) expCount++;
    @(posedge clk);
    #1;
    compareEx(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    expCount = 16'd0;
    rst_n    = 1'b0;
    drive(1'b1, CTRL_LW, 5'd5, 5'd5, 5'd9, 32'hDEAD_BEEF, 1'b0);
    #12;
    chk("rst.ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst.ex_ctrl", {21'd0, bus.ex_ctrl}, 32'd0);
    chk("rst.ex_pc4", bus.ex_pc4, 32'd0);
    chk("rst.ex_rs_data", bus.ex_rs_data, 32'd0);
    chk("rst.ex_rt_data", bus.ex_rt_data, 32'd0);
    chk("rst.ex_imm", bus.ex_imm, 32'd0);
    chk("rst.ex_rs", {27'd0, bus.ex_rs}, 32'd0);
    chk("rst.ex_rt", {27'd0, bus.ex_rt}, 32'd0);
    chk("rst.ex_wr_reg", {27'd0, bus.ex_wr_reg}, 32'd0);
    chk("rst.ex_funct", {26'd0, bus.ex_funct}, 32'd0);
    chk("rst.stall", {31'd0, bus.stall}, 32'd0);
    chk("rst.stall_count", {16'd0, bus.stall_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("rtype",    1'b1, CTRL_RTYPE, 5'd9,  5'd10, 5'd8, 32'h0000_0100, 1'b0, 1'b0);
    step("lw5",      1'b1, CTRL_LW,    5'd2,  5'd5,  5'd0, 32'h0000_0104, 1'b0, 1'b0);
    step("use5_stl", 1'b1, CTRL_RTYPE, 5'd5,  5'd6,  5'd7, 32'h0000_0108, 1'b0, 1'b1);
    step("use5_cap", 1'b1, CTRL_RTYPE, 5'd5,  5'd6,  5'd7, 32'h0000_0108, 1'b0, 1'b0);
    step("lw0",      1'b1, CTRL_LW,    5'd1,  5'd0,  5'd0, 32'h0000_010C, 1'b0, 1'b0);
    step("use0",     1'b1, CTRL_RTYPE, 5'd0,  5'd0,  5'd2, 32'h0000_0110, 1'b0, 1'b0);
    step("lw7a",     1'b1, CTRL_LW,    5'd1,  5'd7,  5'd0, 32'h0000_0114, 1'b0, 1'b0);
    step("lw7b",     1'b1, CTRL_LW,    5'd3,  5'd7,  5'd0, 32'h0000_0118, 1'b0, 1'b0);
    step("flush",    1'b1, CTRL_RTYPE, 5'd7,  5'd1,  5'd2, 32'h0000_011C, 1'b1, 1'b0);
    step("lw4",      1'b1, CTRL_LW,    5'd1,  5'd4,  5'd0, 32'h0000_0120, 1'b0, 1'b0);
    step("invalid",  1'b0, CTRL_RTYPE, 5'd4,  5'd4,  5'd6, 32'h0000_0124, 1'b0, 1'b0);
    step("jal",      1'b1, CTRL_JAL,   5'd0,  5'd0,  5'd3, 32'h0000_0040, 1'b0, 1'b0);
    step("lw12",     1'b1, CTRL_LW,    5'd2,  5'd12, 5'd0, 32'h0000_0044, 1'b0, 1'b0);
    step("sw_stl",   1'b1, CTRL_SW,    5'd1,  5'd12, 5'd0, 32'h0000_0048, 1'b0, 1'b1);
    step("sw_cap",   1'b1, CTRL_SW,    5'd1,  5'd12, 5'd0, 32'h0000_0048, 1'b0, 1'b0);
    step("lw14",     1'b1, CTRL_LW,    5'd1,  5'd14, 5'd0, 32'h0000_004C, 1'b0, 1'b0);
    step("beq_stl",  1'b1, CTRL_BEQ,   5'd2,  5'd14, 5'd0, 32'h0000_0050, 1'b0, 1'b1);
    step("beq_cap",  1'b1, CTRL_BEQ,   5'd2,  5'd14, 5'd0, 32'h0000_0050, 1'b0, 1'b0);
    step("lw13",     1'b1, CTRL_LW,    5'd1,  5'd13, 5'd0, 32'h0000_0054, 1'b0, 1'b0);

    // Reset in the middle of a stall cycle.
    @(negedge clk);
    drive(1'b1, CTRL_RTYPE, 5'd13, 5'd2, 5'd4, 32'h0000_0058, 1'b0);
    #1;
    chk("midrst.stall_before", {31'd0, bus.stall}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("midrst.stall", {31'd0, bus.stall}, 32'd0);
    chk("midrst.stall_count", {16'd0, bus.stall_count}, 32'd0);
    expCount = 16'd0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step("resume",   1'b1, CTRL_RTYPE, 5'd13, 5'd2,  5'd4, 32'h0000_0058, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
